activation_unit: RTL and testbench

- Fixed-point activation stage placed after a neuron's multiply-accumulate.
- Takes the signed double-width accumulator sum and returns one single-width activation word, registered with a valid flag.
- Three activation modes are available: ReLU, full-table sigmoid ROM ("sigmoid_nor"), and half-table symmetric sigmoid ROM ("sigmoid_LU").
- ACT_TYPE selects the mode at elaboration.

---
 rtl/act_pkg.sv | 52 +++++
 rtl/sigmoid_rom.sv | 75 +++++++
 rtl/activation_unit.sv | 158 +++++++++++++++
 tb/tb_activation_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// Shared defaults, activation-type encodings and elaboration-time helpers for activation_unit.
// Runtime mode selection in activation_unit is enabled by defining ACT_RUNTIME_SEL_EN.
package act_pkg;

    localparam int ACT_DATA_WIDTH       = 16;
    localparam int ACT_WEIGHT_INT_WIDTH = 1;
    localparam int ACT_SIG_SIZE         = 5;

    typedef enum logic [1:0] {
        ACT_RELU    = 2'd0,
        ACT_SIG_NOR = 2'd1,
        ACT_SIG_LU  = 2'd2
    } act_type_e;

    // Maps the ACT_TYPE string to its encoding; -1 marks an unsupported name.
    function automatic int act_type_code(input string name);
        if (name == "relu")        return int'(ACT_RELU);
        if (name == "sigmoid_nor") return int'(ACT_SIG_NOR);
        if (name == "sigmoid_LU")  return int'(ACT_SIG_LU);
        return -1;
    endfunction

    // round-half-up(sigmoid(x_num / 2^x_frac) * 2^frac), optionally clipped to the positive word max.
    function automatic int sigmoid_entry(input int x_num, input int x_frac, input int frac,
                                         input int dw, input bit sat);
        real xr;
        real p;
        int  e;
        xr = real'(x_num) / real'(longint'(1) << x_frac);
        p  = 1.0 / (1.0 + $exp(-xr));
        e  = $rtoi(p * real'(longint'(1) << frac) + 0.5);
        if (sat && (e > (2 ** (dw - 1)) - 1)) begin
            e = (2 ** (dw - 1)) - 1;
        end
        return e;
    endfunction

    // Returns the raw table field, or the field max/min when the integer part overflowed.
    function automatic logic [31:0] clamp_field(input logic [31:0] raw, input logic sign,
                                                input logic ovf, input int size);
        logic [31:0] half_range;
        half_range = 32'd1 << (size - 1);
        if (!ovf) begin
            return raw;
        end
        if (sign) begin
            return half_range;
        end
        return half_range - 32'd1;
    endfunction

endpackage

// File: rtl/sigmoid_rom.sv
// Sigmoid lookup ROM with registered read. HALF=1 stores only magnitudes 0..2^(SIG_SIZE-1)
// and rebuilds negative inputs by symmetry; HALF=0 stores the full signed table.
module sigmoid_rom
    import act_pkg::*;
#(
    parameter int DATA_WIDTH       = ACT_DATA_WIDTH,
    parameter int WEIGHT_INT_WIDTH = ACT_WEIGHT_INT_WIDTH,
    parameter int SIG_SIZE         = ACT_SIG_SIZE,
    parameter bit HALF             = 1'b0
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [SIG_SIZE-1:0]   x,
    output logic [DATA_WIDTH-1:0] value
);

    localparam int F      = DATA_WIDTH - WEIGHT_INT_WIDTH;
    localparam int X_FRAC = SIG_SIZE - WEIGHT_INT_WIDTH;
    localparam int DEPTH  = HALF ? (2 ** (SIG_SIZE - 1)) + 1 : 2 ** SIG_SIZE;

    logic [DATA_WIDTH-1:0] rom_table [DEPTH];
    logic [DATA_WIDTH-1:0] data_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam int X_NUM = (!HALF && (gi >= 2 ** (SIG_SIZE - 1))) ? gi - 2 ** SIG_SIZE : gi;
            assign rom_table[gi] = DATA_WIDTH'(sigmoid_entry(X_NUM, X_FRAC, F, DATA_WIDTH, !HALF));
        end

        if (HALF) begin : g_half
            localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            localparam logic [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(longint'(1) << F);

            logic                neg;
            logic                neg_reg;
            logic [SIG_SIZE-1:0] mag;

            assign neg = x[SIG_SIZE-1];
            assign mag = neg ? (~x) + SIG_SIZE'(1) : x;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                    neg_reg  <= 1'b0;
                end else if (en) begin
                    data_reg <= rom_table[mag];
                    neg_reg  <= neg;
                end
            end

            // Entries are stored unclipped so 1 - sigmoid(m) stays exact for negative inputs.
            always_comb begin
                if (neg_reg) begin
                    value = ONE - data_reg;
                end else if (data_reg > SAT_MAX) begin
                    value = SAT_MAX;
                end else begin
                    value = data_reg;
                end
            end
        end else begin : g_full
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (en) begin
                    data_reg <= rom_table[x];
                end
            end

            assign value = data_reg;
        end
    endgenerate

endmodule

// File: rtl/activation_unit.sv
// Fixed-point activation stage (ReLU / full sigmoid ROM / half sigmoid ROM), one-cycle latency.
// Define ACT_RUNTIME_SEL_EN to build all datapaths and select per sample through act_sel.
module activation_unit
    import act_pkg::*;
#(
    parameter int    DATA_WIDTH       = ACT_DATA_WIDTH,
    parameter int    WEIGHT_INT_WIDTH = ACT_WEIGHT_INT_WIDTH,
    parameter int    SIG_SIZE         = ACT_SIG_SIZE,
    parameter string ACT_TYPE         = "sigmoid_LU"
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [2*DATA_WIDTH-1:0] sum,
`ifdef ACT_RUNTIME_SEL_EN
    input  logic [1:0]              act_sel,
`endif
    output logic [DATA_WIDTH-1:0]   out,
    output logic                    out_valid
);

    localparam int SUM_TOP   = 2 * DATA_WIDTH - 1;
    localparam int FIELD_TOP = SUM_TOP - WEIGHT_INT_WIDTH;
    localparam int ACT_CODE  = act_type_code(ACT_TYPE);

`ifdef ACT_RUNTIME_SEL_EN
    localparam bit BUILD_RELU = 1'b1;
    localparam bit BUILD_NOR  = 1'b1;
    localparam bit BUILD_LU   = 1'b1;
`else
    localparam bit BUILD_RELU = (ACT_CODE == int'(ACT_RELU));
    localparam bit BUILD_NOR  = (ACT_CODE == int'(ACT_SIG_NOR));
    localparam bit BUILD_LU   = (ACT_CODE == int'(ACT_SIG_LU));
`endif

    logic                  sign;
    logic                  ovf;
    logic [SIG_SIZE-1:0]   field_x;
    logic [DATA_WIDTH-1:0] relu_out;
    logic [DATA_WIDTH-1:0] nor_out;
    logic [DATA_WIDTH-1:0] lu_out;
    logic                  out_valid_reg;
    logic                  sum_unused;

    generate
        if (ACT_CODE < 0) begin : g_bad_act_type
            $error("activation_unit: ACT_TYPE must be relu, sigmoid_nor or sigmoid_LU");
        end
    endgenerate

    // Integer bits that disagree with the sign mean the value is outside the table range.
    assign sign       = sum[SUM_TOP];
    assign ovf        = (sum[SUM_TOP -: WEIGHT_INT_WIDTH+1] != {(WEIGHT_INT_WIDTH+1){sign}});
    assign field_x    = SIG_SIZE'(clamp_field(32'(sum[FIELD_TOP -: SIG_SIZE]), sign, ovf, SIG_SIZE));
    assign sum_unused = ^{sum, field_x, ovf};

    generate
        if (BUILD_RELU) begin : g_relu
            localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

            logic [DATA_WIDTH-1:0] relu_value;
            logic [DATA_WIDTH-1:0] relu_reg;

            always_comb begin
                relu_value = sum[FIELD_TOP -: DATA_WIDTH];
                if (sign) begin
                    relu_value = '0;
                end else if (ovf) begin
                    relu_value = SAT_MAX;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    relu_reg <= '0;
                end else if (in_valid) begin
                    relu_reg <= relu_value;
                end
            end

            assign relu_out = relu_reg;
        end else begin : g_no_relu
            assign relu_out = '0;
        end

        if (BUILD_NOR) begin : g_nor
            sigmoid_rom #(
                .DATA_WIDTH       (DATA_WIDTH),
                .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH),
                .SIG_SIZE         (SIG_SIZE),
                .HALF             (1'b0)
            ) u_rom (
                .clk   (clk),
                .rst   (rst),
                .en    (in_valid),
                .x     (field_x),
                .value (nor_out)
            );
        end else begin : g_no_nor
            assign nor_out = '0;
        end

        if (BUILD_LU) begin : g_lu
            sigmoid_rom #(
                .DATA_WIDTH       (DATA_WIDTH),
                .WEIGHT_INT_WIDTH (WEIGHT_INT_WIDTH),
                .SIG_SIZE         (SIG_SIZE),
                .HALF             (1'b1)
            ) u_rom (
                .clk   (clk),
                .rst   (rst),
                .en    (in_valid),
                .x     (field_x),
                .value (lu_out)
            );
        end else begin : g_no_lu
            assign lu_out = '0;
        end
    endgenerate

`ifdef ACT_RUNTIME_SEL_EN
    act_type_e sel_reg;

    // The mode travels with the sample so the output mux matches the registered data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_reg <= ACT_RELU;
        end else if (in_valid) begin
            case (act_sel)
                2'd1:    sel_reg <= ACT_SIG_NOR;
                2'd2:    sel_reg <= ACT_SIG_LU;
                default: sel_reg <= ACT_RELU;
            endcase
        end
    end

    always_comb begin
        case (sel_reg)
            ACT_SIG_NOR: out = nor_out;
            ACT_SIG_LU:  out = lu_out;
            default:     out = relu_out;
        endcase
    end
`else
    assign out = BUILD_RELU ? relu_out : (BUILD_NOR ? nor_out : lu_out);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
        end
    end

    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_activation_unit.sv
// Self-checking bench: one instance per activation mode, directed test-plan vectors plus
// randomized streams checked against a real-arithmetic reference model.
module tb_activation_unit;

    localparam int DW = 16;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [2*DW-1:0] sum;
    logic [DW-1:0] out_relu, out_nor, out_lu;
    logic          valid_relu, valid_nor, valid_lu;

    logic [DW-1:0] outs [3];
    logic          valids [3];
    logic [DW-1:0] m_out [3];
    logic          m_valid;
    string         inst_name [3] = '{"relu", "sigmoid_nor", "sigmoid_LU"};

    int errors = 0;
    int checks = 0;

    activation_unit #(.DATA_WIDTH(16), .WEIGHT_INT_WIDTH(1), .SIG_SIZE(5), .ACT_TYPE("relu")) dut_relu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
`ifdef ACT_RUNTIME_SEL_EN
        .act_sel(2'd0),
`endif
        .out(out_relu), .out_valid(valid_relu)
    );

    activation_unit #(.DATA_WIDTH(16), .WEIGHT_INT_WIDTH(1), .SIG_SIZE(5), .ACT_TYPE("sigmoid_nor")) dut_nor (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
`ifdef ACT_RUNTIME_SEL_EN
        .act_sel(2'd1),
`endif
        .out(out_nor), .out_valid(valid_nor)
    );

    activation_unit #(.DATA_WIDTH(16), .WEIGHT_INT_WIDTH(1), .SIG_SIZE(5), .ACT_TYPE("sigmoid_LU")) dut_lu (
        .clk(clk), .rst(rst), .in_valid(in_valid), .sum(sum),
`ifdef ACT_RUNTIME_SEL_EN
        .act_sel(2'd2),
`endif
        .out(out_lu), .out_valid(valid_lu)
    );

    assign outs[0]   = out_relu;
    assign outs[1]   = out_nor;
    assign outs[2]   = out_lu;
    assign valids[0] = valid_relu;
    assign valids[1] = valid_nor;
    assign valids[2] = valid_lu;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value = sum / 2^30; ReLU truncates to 15 fraction bits, saturating at >= 1.0.
    function automatic logic [DW-1:0] model_relu(input logic [31:0] s);
        longint v;
        v = longint'(signed'(s));
        if (v < 0) return '0;
        if (v >= 64'sd1073741824) return 16'h7FFF;
        return DW'(v / 32768);
    endfunction

    // Reference: x = floor(value * 16) clamped to [-16, 15], then rounded sigmoid(x / 16) * 2^15.
    function automatic logic [DW-1:0] model_sig(input logic [31:0] s);
        longint v;
        longint q;
        real    p;
        int     e;
        v = longint'(signed'(s));
        q = v >>> 26;
        if (q > 15) q = 15;
        if (q < -16) q = -16;
        p = 1.0 / (1.0 + $exp(-real'(q) / 16.0));
        e = $rtoi(p * 32768.0 + 0.5);
        if (e > 32767) e = 32767;
        return DW'(e);
    endfunction

    task automatic drive(input logic v, input logic [31:0] s);
        in_valid = v;
        sum      = s;
        m_valid  = v;
        if (v) begin
            m_out[0] = model_relu(s);
            m_out[1] = model_sig(s);
            m_out[2] = model_sig(s);
        end
    endtask

    function automatic logic [31:0] random_sum();
        logic [31:0] r;
        logic [31:0] edge_vals [6];
        edge_vals = '{32'h3FFFFFFF, 32'hC0000000, 32'h04000000, 32'hFC000000, 32'h7FFFFFFF, 32'hBFFFFFFF};
        r = $urandom();
        case ($urandom_range(0, 3))
            0:       return r;
            3:       return edge_vals[$urandom_range(0, 5)];
            default: return {r[30], r[30:0]};
        endcase
    endfunction

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        sum      = '0;
        m_valid  = 1'b0;
        for (int k = 0; k < 3; k++) m_out[k] = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (valids[k] !== 1'b0 || outs[k] !== '0) begin
                errors++;
                $display("FAIL reset %s: got valid=%0b out=%0d required valid=0 out=0", inst_name[k], valids[k], outs[k]);
            end
        end
        $display("reset txn: rst held 2 cycles");
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] vec [5];
        logic [15:0] exp_relu [5];
        logic [15:0] exp_sig [5];
        logic [15:0] want;
        vec      = '{32'h00000000, 32'h20000000, 32'hE0000000, 32'h40000000, 32'h80000000};
        exp_relu = '{16'd0, 16'd16384, 16'd0, 16'd32767, 16'd0};
        exp_sig  = '{16'd16384, 16'd20397, 16'd12371, 16'd23547, 16'd8813};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(1'b1, vec[i]);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                want = (k == 0) ? exp_relu[i] : exp_sig[i];
                checks++;
                if (valids[k] !== 1'b1 || outs[k] !== want) begin
                    errors++;
                    $display("FAIL directed %s sum=0x%08h: got valid=%0b out=%0d required valid=1 out=%0d",
                             inst_name[k], vec[i], valids[k], outs[k], want);
                end
            end
            $display("directed txn: sum=0x%08h relu=%0d nor=%0d lu=%0d", vec[i], out_relu, out_nor, out_lu);
            drive(1'b0, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, random_sum());
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (valids[k] !== m_valid || outs[k] !== m_out[k]) begin
                    errors++;
                    $display("FAIL back_to_back[%0d] %s: got valid=%0b out=%0d required valid=%0b out=%0d",
                             n, inst_name[k], valids[k], outs[k], m_valid, m_out[k]);
                end
            end
            $display("back_to_back txn %0d: valid=%0b relu=%0d nor=%0d lu=%0d", n, valid_lu, out_relu, out_nor, out_lu);
            if (n < 3) drive(1'b1, random_sum());
            else       drive(1'b0, random_sum());
        end
    endtask

    task automatic test_random();
        logic        v;
        logic [31:0] s;
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (valids[k] !== m_valid || outs[k] !== m_out[k]) begin
                    errors++;
                    $display("FAIL random[%0d] %s: got valid=%0b out=%0d required valid=%0b out=%0d",
                             n, inst_name[k], valids[k], outs[k], m_valid, m_out[k]);
                end
            end
            v = ($urandom_range(0, 3) != 0);
            s = random_sum();
            drive(v, s);
            $display("random txn %0d: in_valid=%0b sum=0x%08h", n, v, s);
        end
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        drive(1'b1, random_sum());
        @(negedge clk);
        drive(1'b1, random_sum());
        #2 rst = 1'b1;
        m_valid = 1'b0;
        for (int k = 0; k < 3; k++) m_out[k] = '0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (valids[k] !== 1'b0 || outs[k] !== '0) begin
                errors++;
                $display("FAIL async_reset %s: got valid=%0b out=%0d required valid=0 out=0", inst_name[k], valids[k], outs[k]);
            end
        end
        $display("midstream reset txn: rst asserted between edges");
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (valids[k] !== m_valid || outs[k] !== m_out[k]) begin
                    errors++;
                    $display("FAIL post_reset[%0d] %s: got valid=%0b out=%0d required valid=%0b out=%0d",
                             n, inst_name[k], valids[k], outs[k], m_valid, m_out[k]);
                end
            end
            $display("post reset txn %0d: valid=%0b relu=%0d nor=%0d lu=%0d", n, valid_lu, out_relu, out_nor, out_lu);
            case (n)
                0: begin rst = 1'b0; drive(1'b0, 32'h0); end
                1: drive(1'b0, 32'h0);
                2: drive(1'b1, 32'h20000000);
                default: drive(1'b0, 32'h0);
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time budget, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
